// File: rtl/idelay_tap_scanner.sv
// idelay_tap_scanner
// Sweeps the 32 IDELAYE2 taps in VAR_LOAD mode, counts data/reference
// mismatches at every tap, then loads the centre of the longest error-free
// run of taps.
// Optional feature: define IDELAY_SCAN_STATS_EN to add the err_map output,
// which records which taps saw at least one mismatch.
module idelay_tap_scanner #(
  parameter int SETTLE_CYCLES = 16,
  parameter int WINDOW        = 1024
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        cal_rdy,
  input  logic        start,
  input  logic        dly_out,
  input  logic        ref_data,
  output logic        dly_ld,
  output logic [4:0]  dly_delay_in,
  output logic        busy,
  output logic        done,
  output logic        fail,
`ifdef IDELAY_SCAN_STATS_EN
  output logic [31:0] err_map,
`endif
  output logic [4:0]  best_tap
);

  localparam int ERR_W   = $clog2(WINDOW + 1);
  localparam int CNT_MAX = (SETTLE_CYCLES > WINDOW) ? SETTLE_CYCLES : WINDOW;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] WINDOW_LAST = CNT_W'(WINDOW - 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO    = CNT_W'(0);
  localparam logic [ERR_W-1:0] ERR_ONE     = ERR_W'(1);
  localparam logic [ERR_W-1:0] ERR_ZERO    = ERR_W'(0);
  localparam logic [ERR_W-1:0] ERR_SAT     = {ERR_W{1'b1}};

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_SETTLE  = 3'd2,
    S_MEASURE = 3'd3,
    S_EVAL    = 3'd4,
    S_FINAL   = 3'd5,
    S_DONE    = 3'd6
  } state_t;

  state_t           state_q, state_d;
  logic [4:0]       tap_q, tap_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
  logic [4:0]       cur_start_q, cur_start_d;
  logic [5:0]       cur_len_q, cur_len_d;
  logic [4:0]       best_start_q, best_start_d;
  logic [5:0]       best_len_q, best_len_d;
  logic             dly_ld_q, dly_ld_d;
  logic [4:0]       dly_val_q, dly_val_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             fail_q, fail_d;
  logic [4:0]       best_tap_q, best_tap_d;
`ifdef IDELAY_SCAN_STATS_EN
  logic [31:0]      err_map_q, err_map_d;
`endif

  // Matched two-stage pipelines keep data and reference aligned at the compare.
  logic dly_s1_q, dly_s2_q, ref_s1_q, ref_s2_q;

  logic       scan_start_s;
  logic       mismatch_s;
  logic [5:0] cur_len_inc_s;

  assign scan_start_s  = start && cal_rdy;
  assign mismatch_s    = (dly_s2_q != ref_s2_q);
  assign cur_len_inc_s = cur_len_q + 6'd1;

  // Input synchronising pipeline for the delayed data and its reference.
  always_ff @(posedge CLK) begin
    if (RST) begin
      dly_s1_q <= 1'b0;
      dly_s2_q <= 1'b0;
      ref_s1_q <= 1'b0;
      ref_s2_q <= 1'b0;
    end else begin
      dly_s1_q <= dly_out;
      dly_s2_q <= dly_s1_q;
      ref_s1_q <= ref_data;
      ref_s2_q <= ref_s1_q;
    end
  end

  // Next-state, run tracking and registered-output logic of the scan FSM.
  always_comb begin
    state_d      = state_q;
    tap_d        = tap_q;
    cnt_d        = cnt_q;
    err_cnt_d    = err_cnt_q;
    cur_start_d  = cur_start_q;
    cur_len_d    = cur_len_q;
    best_start_d = best_start_q;
    best_len_d   = best_len_q;
    dly_ld_d     = 1'b0;
    dly_val_d    = dly_val_q;
    busy_d       = busy_q;
    done_d       = done_q;
    fail_d       = fail_q;
    best_tap_d   = best_tap_q;
`ifdef IDELAY_SCAN_STATS_EN
    err_map_d    = err_map_q;
`endif

    case (state_q)
      S_IDLE, S_DONE: begin
        if (scan_start_s) begin
          state_d      = S_LOAD;
          tap_d        = 5'd0;
          busy_d       = 1'b1;
          done_d       = 1'b0;
          fail_d       = 1'b0;
          cur_start_d  = 5'd0;
          cur_len_d    = 6'd0;
          best_start_d = 5'd0;
          best_len_d   = 6'd0;
`ifdef IDELAY_SCAN_STATS_EN
          err_map_d    = 32'd0;
`endif
        end else begin
          state_d = state_q;
        end
      end
      S_LOAD: begin
        dly_ld_d  = 1'b1;
        dly_val_d = tap_q;
        cnt_d     = CNT_ZERO;
        state_d   = S_SETTLE;
      end
      S_SETTLE: begin
        err_cnt_d = ERR_ZERO;
        if (cnt_q == SETTLE_LAST) begin
          cnt_d   = CNT_ZERO;
          state_d = S_MEASURE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_MEASURE: begin
        if (mismatch_s && (err_cnt_q != ERR_SAT)) begin
          err_cnt_d = err_cnt_q + ERR_ONE;
        end else begin
          err_cnt_d = err_cnt_q;
        end
        if (cnt_q == WINDOW_LAST) begin
          cnt_d   = CNT_ZERO;
          state_d = S_EVAL;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_EVAL: begin
        if (err_cnt_q == ERR_ZERO) begin
          cur_len_d = cur_len_inc_s;
          if (cur_len_q == 6'd0) begin
            cur_start_d = tap_q;
          end else begin
            cur_start_d = cur_start_q;
          end
          // Strict greater-than keeps the lowest-tap run when lengths tie.
          if (cur_len_inc_s > best_len_q) begin
            best_start_d = (cur_len_q == 6'd0) ? tap_q : cur_start_q;
            best_len_d   = cur_len_inc_s;
          end else begin
            best_len_d = best_len_q;
          end
        end else begin
          cur_len_d = 6'd0;
        end
`ifdef IDELAY_SCAN_STATS_EN
        err_map_d[tap_q] = (err_cnt_q != ERR_ZERO);
`endif
        if (tap_q == 5'd31) begin
          state_d = S_FINAL;
        end else begin
          tap_d   = tap_q + 5'd1;
          state_d = S_LOAD;
        end
      end
      S_FINAL: begin
        if (best_len_q == 6'd0) begin
          fail_d     = 1'b1;
          best_tap_d = 5'd0;
        end else begin
          fail_d     = 1'b0;
          best_tap_d = 5'({1'b0, best_start_q} + ((best_len_q - 6'd1) >> 1));
        end
        dly_val_d = best_tap_d;
        dly_ld_d  = 1'b1;
        done_d    = 1'b1;
        busy_d    = 1'b0;
        state_d   = S_DONE;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase

    // Losing IDELAYCTRL ready mid-scan abandons the scan; the tap value stays put.
    if (!cal_rdy && (state_q != S_IDLE) && (state_q != S_DONE)) begin
      state_d   = S_IDLE;
      dly_ld_d  = 1'b0;
      dly_val_d = dly_val_q;
      busy_d    = 1'b0;
      done_d    = 1'b0;
    end else begin
      busy_d = busy_d;
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= S_IDLE;
      tap_q        <= 5'd0;
      cnt_q        <= CNT_ZERO;
      err_cnt_q    <= ERR_ZERO;
      cur_start_q  <= 5'd0;
      cur_len_q    <= 6'd0;
      best_start_q <= 5'd0;
      best_len_q   <= 6'd0;
      dly_ld_q     <= 1'b0;
      dly_val_q    <= 5'd0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      fail_q       <= 1'b0;
      best_tap_q   <= 5'd0;
`ifdef IDELAY_SCAN_STATS_EN
      err_map_q    <= 32'd0;
`endif
    end else begin
      state_q      <= state_d;
      tap_q        <= tap_d;
      cnt_q        <= cnt_d;
      err_cnt_q    <= err_cnt_d;
      cur_start_q  <= cur_start_d;
      cur_len_q    <= cur_len_d;
      best_start_q <= best_start_d;
      best_len_q   <= best_len_d;
      dly_ld_q     <= dly_ld_d;
      dly_val_q    <= dly_val_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      fail_q       <= fail_d;
      best_tap_q   <= best_tap_d;
`ifdef IDELAY_SCAN_STATS_EN
      err_map_q    <= err_map_d;
`endif
    end
  end

  assign dly_ld       = dly_ld_q;
  assign dly_delay_in = dly_val_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign fail         = fail_q;
  assign best_tap     = best_tap_q;
`ifdef IDELAY_SCAN_STATS_EN
  assign err_map      = err_map_q;
`endif

endmodule
